audio_mixer_n: RTL

// Parametrised N-channel stereo audio mixer, successor to the fixed beeper/AY/soundrive mixer.

---
 rtl/audio_mixer_n_pkg.sv | 30 +++
 rtl/audio_mixer_n_dac.sv | 36 +++
 rtl/audio_mixer_n.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/audio_mixer_n_pkg.sv
// Shared types for the N-channel stereo mixer: pan codes, FSM states and
// cfg byte field positions, plus small helpers deciding which side a channel feeds.
package audio_mixer_n_pkg;

    localparam int unsigned CFG_W   = 8;
    localparam int unsigned PAN_LSB = 4;

    typedef enum logic [1:0] {
        PAN_MUTE = 2'b00,
        PAN_L    = 2'b01,
        PAN_R    = 2'b10,
        PAN_LR   = 2'b11
    } pan_t;

    typedef enum logic [1:0] {
        MIX_SCAN  = 2'd0,
        MIX_FLUSH = 2'd1,
        MIX_LATCH = 2'd2
    } mixer_state_t;

    // Mono sends any audible channel to both sides.
    function automatic logic feeds_left(input pan_t pan, input logic mono);
        return mono ? (pan != PAN_MUTE) : (pan == PAN_L || pan == PAN_LR);
    endfunction

    function automatic logic feeds_right(input pan_t pan, input logic mono);
        return mono ? (pan != PAN_MUTE) : (pan == PAN_R || pan == PAN_LR);
    endfunction

endpackage

// File: rtl/audio_mixer_n_dac.sv
// First-order sigma-delta modulator driving one audio pin.
// Ports: clk28/rst_n clock and async active-low reset; en clears the
// modulator when low; din is the PCM level; dout is the 1-bit stream whose
// ones density equals din / 2**W.
module sigma_delta_dac #(
    parameter int unsigned W = 12
) (
    input  logic         clk28,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic         dout
);

    logic [W:0] acc_q;
    logic [W:0] acc_d;

    // The carry out of the W-bit integrator is the output bit; it is dropped before the next add.
    always_comb begin
        acc_d = {1'b0, acc_q[W-1:0]} + (W+1)'(din);
        if (!en) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign dout = acc_q[W];

endmodule

// File: rtl/audio_mixer_n.sv
// N-channel stereo mixer: scans the channels one per clock, scales each by
// its volume, routes it left/right by pan (or to both in mono), sums,
// shifts and saturates each side, and drives two sigma-delta bitstreams.
// Ports: clk28, rst_n (async, active-low); en (low = idle/silent); mono;
// ch_data (packed unsigned samples); cfg_wr/cfg_addr/cfg_data (volume and
// pan write port); sample_l/sample_r with sample_valid pulse; dac_l/dac_r.
module audio_mixer_n
    import audio_mixer_n_pkg::*;
#(
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned CH_W     = 8,
    parameter int unsigned VOL_W    = 4,
    parameter int unsigned OUT_W    = 12,
    parameter int unsigned SHIFT    = 3
) (
    input  logic                        clk28,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        mono,
    input  logic [CHANNELS*CH_W-1:0]    ch_data,
    input  logic                        cfg_wr,
    input  logic [$clog2(CHANNELS)-1:0] cfg_addr,
    input  logic [CFG_W-1:0]            cfg_data,
    output logic [OUT_W-1:0]            sample_l,
    output logic [OUT_W-1:0]            sample_r,
    output logic                        sample_valid,
    output logic                        dac_l,
    output logic                        dac_r
);

    localparam int unsigned IDX_W    = $clog2(CHANNELS);
    localparam int unsigned PROD_W   = CH_W + VOL_W;
    localparam int unsigned ACC_W    = PROD_W + IDX_W;
    localparam int unsigned SAT_W    = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam int unsigned LAST_IDX = CHANNELS - 1;

    logic [VOL_W-1:0]  vol_q [CHANNELS];
    logic [VOL_W-1:0]  vol_d [CHANNELS];
    pan_t              pan_q [CHANNELS];
    pan_t              pan_d [CHANNELS];
    logic [CH_W-1:0]   ch_arr [CHANNELS];

    mixer_state_t      state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [PROD_W-1:0] prod_q, prod_d;
    pan_t              prod_pan_q, prod_pan_d;
    logic              prod_vld_q, prod_vld_d;
    logic [ACC_W-1:0]  acc_l_q, acc_l_d;
    logic [ACC_W-1:0]  acc_r_q, acc_r_d;
    logic [OUT_W-1:0]  sample_l_q, sample_l_d;
    logic [OUT_W-1:0]  sample_r_q, sample_r_d;
    logic              sample_valid_q, sample_valid_d;
    logic              unused_cfg_bits;

    // Bits of the cfg byte outside the volume and pan fields carry no meaning.
    assign unused_cfg_bits = ^cfg_data;

    function automatic logic [OUT_W-1:0] saturate(input logic [ACC_W-1:0] acc);
        logic [SAT_W-1:0] scaled;
        scaled = SAT_W'(acc >> SHIFT);
        if (scaled > SAT_W'({OUT_W{1'b1}})) begin
            return '1;
        end
        return OUT_W'(scaled);
    endfunction

    // Unpack the sample bus so the scan can index it by channel.
    always_comb begin
        for (int k = 0; k < int'(CHANNELS); k++) begin
            ch_arr[k] = ch_data[k*CH_W +: CH_W];
        end
    end

    // Config regfile: out-of-range addresses are dropped; accepted even while idle.
    always_comb begin
        vol_d = vol_q;
        pan_d = pan_q;
        if (cfg_wr && (32'(cfg_addr) < 32'(CHANNELS))) begin
            vol_d[cfg_addr] = cfg_data[VOL_W-1:0];
            pan_d[cfg_addr] = pan_t'(cfg_data[PAN_LSB +: 2]);
        end
    end

    // Scan FSM: stage 1 multiplies the selected channel, stage 2 accumulates it
    // one cycle later; FLUSH drains the pipeline before LATCH publishes the sums.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        prod_d         = prod_q;
        prod_pan_d     = prod_pan_q;
        prod_vld_d     = 1'b0;
        acc_l_d        = acc_l_q;
        acc_r_d        = acc_r_q;
        sample_l_d     = sample_l_q;
        sample_r_d     = sample_r_q;
        sample_valid_d = 1'b0;

        if (prod_vld_q) begin
            if (feeds_left(prod_pan_q, mono)) begin
                acc_l_d = acc_l_q + ACC_W'(prod_q);
            end
            if (feeds_right(prod_pan_q, mono)) begin
                acc_r_d = acc_r_q + ACC_W'(prod_q);
            end
        end

        case (state_q)
            MIX_SCAN: begin
                prod_d     = PROD_W'(ch_arr[idx_q]) * PROD_W'(vol_q[idx_q]);
                prod_pan_d = pan_q[idx_q];
                prod_vld_d = 1'b1;
                if (idx_q == IDX_W'(LAST_IDX)) begin
                    idx_d   = '0;
                    state_d = MIX_FLUSH;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            MIX_FLUSH: begin
                // idx doubles as the two-cycle flush counter.
                if (idx_q == IDX_W'(1)) begin
                    idx_d   = '0;
                    state_d = MIX_LATCH;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            MIX_LATCH: begin
                sample_l_d     = saturate(acc_l_q);
                sample_r_d     = saturate(acc_r_q);
                sample_valid_d = 1'b1;
                acc_l_d        = '0;
                acc_r_d        = '0;
                idx_d          = '0;
                state_d        = MIX_SCAN;
            end
            default: begin
                idx_d   = '0;
                state_d = MIX_SCAN;
            end
        endcase

        // Disabling abandons any partial period and silences the outputs.
        if (!en) begin
            state_d        = MIX_SCAN;
            idx_d          = '0;
            prod_d         = '0;
            prod_vld_d     = 1'b0;
            acc_l_d        = '0;
            acc_r_d        = '0;
            sample_l_d     = '0;
            sample_r_d     = '0;
            sample_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(CHANNELS); k++) begin
                vol_q[k] <= '1;
                pan_q[k] <= PAN_LR;
            end
            state_q        <= MIX_SCAN;
            idx_q          <= '0;
            prod_q         <= '0;
            prod_pan_q     <= PAN_MUTE;
            prod_vld_q     <= 1'b0;
            acc_l_q        <= '0;
            acc_r_q        <= '0;
            sample_l_q     <= '0;
            sample_r_q     <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            vol_q          <= vol_d;
            pan_q          <= pan_d;
            state_q        <= state_d;
            idx_q          <= idx_d;
            prod_q         <= prod_d;
            prod_pan_q     <= prod_pan_d;
            prod_vld_q     <= prod_vld_d;
            acc_l_q        <= acc_l_d;
            acc_r_q        <= acc_r_d;
            sample_l_q     <= sample_l_d;
            sample_r_q     <= sample_r_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    assign sample_l     = sample_l_q;
    assign sample_r     = sample_r_q;
    assign sample_valid = sample_valid_q;

    sigma_delta_dac #(.W(OUT_W)) u_dac_l (
        .clk28 (clk28),
        .rst_n (rst_n),
        .en    (en),
        .din   (sample_l_q),
        .dout  (dac_l)
    );

    sigma_delta_dac #(.W(OUT_W)) u_dac_r (
        .clk28 (clk28),
        .rst_n (rst_n),
        .en    (en),
        .din   (sample_r_q),
        .dout  (dac_r)
    );

endmodule
